// File: rtl/discrete_audio_mixer.sv
// Weighted N-channel audio mixer: one shared multiplier walks the channels between sample strobes.
// Define MIXER_CLIP_COUNT_EN to add the saturating clip_count output.

module discrete_audio_mixer_chan #(
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [15:0]           sample,
  input  logic [GAIN_WIDTH-1:0] gain,
  output logic [15:0]           sample_snap,
  output logic [GAIN_WIDTH-1:0] gain_snap
);
  logic [15:0]           sample_d, sample_q;
  logic [GAIN_WIDTH-1:0] gain_d, gain_q;

  always_comb begin
    sample_d = load ? sample : sample_q;
    gain_d   = load ? gain   : gain_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      gain_q   <= '0;
    end else begin
      sample_q <= sample_d;
      gain_q   <= gain_d;
    end
  end

  assign sample_snap = sample_q;
  assign gain_snap   = gain_q;
endmodule

module discrete_audio_mixer #(
  parameter int NUM_INPUTS     = 4,
  parameter int GAIN_WIDTH     = 8,
  parameter int GAIN_FRAC_BITS = 7
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             audio_clk_en,
  input  logic [16*NUM_INPUTS-1:0]         in,
  input  logic [GAIN_WIDTH*NUM_INPUTS-1:0] gain,
  output logic [15:0]                      out,
  output logic                             out_valid,
  output logic                             busy,
`ifdef MIXER_CLIP_COUNT_EN
  output logic [15:0]                      clip_count,
  output logic                             overrun
`else
  output logic                             overrun
`endif
);
  localparam int ACC_W = 16 + GAIN_WIDTH + $clog2(NUM_INPUTS) + 1;
  localparam int R_W   = ACC_W - GAIN_FRAC_BITS;
  localparam int P_W   = 17 + GAIN_WIDTH;
  localparam int CH_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CH_W-1:0]         LAST_CH  = CH_W'(NUM_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] HALF_LSB = ACC_W'(2 ** (GAIN_FRAC_BITS - 1));
  localparam logic signed [R_W-1:0]   R_MAX    = R_W'(32767);
  localparam logic signed [R_W-1:0]   R_MIN    = R_W'(-32768);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, FINISH = 2'd2} state_t;

  state_t                  state_d, state_q;
  logic [CH_W-1:0]         ch_d, ch_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [15:0]             out_d, out_q;
  logic                    out_valid_d, out_valid_q;
  logic                    overrun_d, overrun_q;
  logic                    snap_load;

  logic [NUM_INPUTS-1:0][15:0]           snap_in;
  logic [NUM_INPUTS-1:0][GAIN_WIDTH-1:0] snap_gain;

  // Inputs are frozen on the strobe so upstream stages may move on mid-sample.
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_chan
    discrete_audio_mixer_chan #(.GAIN_WIDTH(GAIN_WIDTH)) u_chan (
      .clk         (clk),
      .reset       (reset),
      .load        (snap_load),
      .sample      (in[16*k +: 16]),
      .gain        (gain[GAIN_WIDTH*k +: GAIN_WIDTH]),
      .sample_snap (snap_in[k]),
      .gain_snap   (snap_gain[k])
    );
  end

  logic signed [15:0]         cur_sample;
  logic signed [GAIN_WIDTH:0] cur_gain;
  logic signed [P_W-1:0]      prod;
  logic signed [ACC_W-1:0]    rnd_sum;
  logic signed [R_W-1:0]      r;
  logic [15:0]                sat;
  logic                       clipped;

  always_comb begin
    cur_sample = snap_in[ch_q];
    cur_gain   = {1'b0, snap_gain[ch_q]};
    prod       = P_W'(cur_sample) * P_W'(cur_gain);
    rnd_sum    = acc_q + HALF_LSB;
    r          = R_W'(rnd_sum >>> GAIN_FRAC_BITS);
    sat        = r[15:0];
    clipped    = 1'b0;
    if (r > R_MAX) begin
      sat     = 16'h7fff;
      clipped = 1'b1;
    end else if (r < R_MIN) begin
      sat     = 16'h8000;
      clipped = 1'b1;
    end
  end

  // A strobe always restarts the sample, aborting any mix still in flight.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    acc_d       = acc_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;
    snap_load   = 1'b0;
    if (audio_clk_en) begin
      snap_load = 1'b1;
      acc_d     = '0;
      ch_d      = '0;
      state_d   = ACCUM;
      if (state_q != IDLE) overrun_d = 1'b1;
    end else begin
      unique case (state_q)
        ACCUM: begin
          acc_d = acc_q + ACC_W'(prod);
          ch_d  = ch_q + CH_W'(1);
          if (ch_q == LAST_CH) state_d = FINISH;
        end
        FINISH: begin
          out_d       = sat;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE) | out_valid_q;

`ifdef MIXER_CLIP_COUNT_EN
  logic        finishing;
  logic [15:0] clip_cnt_d, clip_cnt_q;

  always_comb begin
    finishing  = (state_q == FINISH) && !audio_clk_en;
    clip_cnt_d = clip_cnt_q;
    if (finishing && clipped && (clip_cnt_q != 16'hffff)) clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) clip_cnt_q <= '0;
    else       clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count = clip_cnt_q;
`endif
endmodule

// File: tb/tb_discrete_audio_mixer.sv
// Self-checking bench for discrete_audio_mixer: vector table, corner sequences, random vs. model.
module tb_discrete_audio_mixer;
  logic        clk = 1'b0;
  logic        reset, audio_clk_en;
  logic [63:0] in_v;
  logic [31:0] gain_v;
  logic [15:0] out_w;
  logic        out_valid, busy, overrun;
`ifdef MIXER_CLIP_COUNT_EN
  logic [15:0] clip_count;
  int          exp_clips = 0;
`endif
  int n_pass = 0, n_total = 0;

  always #5 clk = ~clk;

  discrete_audio_mixer #(.NUM_INPUTS(4), .GAIN_WIDTH(8), .GAIN_FRAC_BITS(7)) dut (
    .clk          (clk),
    .reset        (reset),
    .audio_clk_en (audio_clk_en),
    .in           (in_v),
    .gain         (gain_v),
    .out          (out_w),
    .out_valid    (out_valid),
    .busy         (busy),
`ifdef MIXER_CLIP_COUNT_EN
    .clip_count   (clip_count),
`endif
    .overrun      (overrun)
  );

  typedef struct {
    logic [63:0] vin;
    logic [31:0] vg;
    int          exp_out;
    bit          exp_clip;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [31:0] g4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Exact weighted sum, floor((sum + 0.5 LSB) / 128), then clamp to 16-bit signed.
  function automatic void model(input logic [63:0] vin, input logic [31:0] vg,
                                output int res, output bit clip);
    longint sum = 0;
    longint t, q;
    for (int k = 0; k < 4; k++)
      sum += longint'($signed(vin[16*k +: 16])) * longint'(vg[8*k +: 8]);
    t = sum + 64;
    q = t / 128;
    if (t < 0 && (q * 128 != t)) q = q - 1;
    clip = 1'b1;
    if (q > 32767) res = 32767;
    else if (q < -32768) res = -32768;
    else begin
      res  = int'(q);
      clip = 1'b0;
    end
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Strobe once, then watch 12 cycles: first out_valid latency, value, pulse count, busy profile.
  task automatic run_sample(input logic [63:0] vin, input logic [31:0] vg,
                            output int got, output int lat, output int pulses,
                            output logic [11:0] bz);
    @(negedge clk);
    in_v = vin; gain_v = vg; audio_clk_en = 1'b1;
    got = 0; lat = -1; pulses = 0; bz = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      audio_clk_en = 1'b0;
      bz[k-1] = busy;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          got = int'($signed(out_w));
        end
      end
    end
  endtask

  initial begin
    int          got, lat, pulses, exp_v;
    bit          clip;
    logic [11:0] bz;
    logic [63:0] va, vb;
    logic [31:0] ga, gb;

    tbl[0]  = '{pack4(1000, 2000, -500, 0),              g4(128, 128, 128, 128), 2500,   1'b0};
    tbl[1]  = '{pack4(20000, 20000, 20000, 20000),       g4(128, 128, 128, 128), 32767,  1'b1};
    tbl[2]  = '{pack4(-20000, -20000, -20000, -20000),   g4(128, 128, 128, 128), -32768, 1'b1};
    tbl[3]  = '{pack4(3, 555, -777, 9),                  g4(64, 0, 0, 0),        2,      1'b0};
    tbl[4]  = '{pack4(-3, 1234, -1, 32767),              g4(64, 0, 0, 0),        -1,     1'b0};
    tbl[5]  = '{pack4(1, -9, 100, 4),                    g4(64, 0, 0, 0),        1,      1'b0};
    tbl[6]  = '{pack4(32767, 32767, 32767, 32767),       g4(255, 255, 255, 255), 32767,  1'b1};
    tbl[7]  = '{pack4(-32768, -32768, -32768, -32768),   g4(255, 255, 255, 255), -32768, 1'b1};
    tbl[8]  = '{pack4(100, -100, 50, -50),               g4(255, 1, 128, 0),     248,    1'b0};
    tbl[9]  = '{pack4(0, 0, 0, 0),                       g4(200, 17, 3, 255),    0,      1'b0};
    tbl[10] = '{pack4(-1, 0, 0, 0),                      g4(1, 0, 0, 0),         0,      1'b0};
    tbl[11] = '{pack4(32767, 0, 0, 0),                   g4(128, 0, 0, 0),       32767,  1'b0};
    tbl[12] = '{pack4(-32768, 0, 0, 0),                  g4(128, 0, 0, 0),       -32768, 1'b0};
    tbl[13] = '{pack4(32767, 1, 0, 0),                   g4(128, 128, 0, 0),     32767,  1'b1};

    reset = 1'b1; audio_clk_en = 1'b0; in_v = '0; gain_v = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_out", int'(out_w), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overrun", int'(overrun), 0);
`ifdef MIXER_CLIP_COUNT_EN
    check("reset_clip_count", int'(clip_count), 0);
`endif

    // Reset and strobe in the same cycle: reset must win.
    @(negedge clk);
    reset = 1'b1; audio_clk_en = 1'b1; in_v = pack4(1000, 1000, 1000, 1000); gain_v = g4(128, 128, 128, 128);
    @(negedge clk);
    reset = 1'b0; audio_clk_en = 1'b0;
    check("rst_wins_busy", int'(busy), 0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("rst_wins_no_valid", pulses, 0);

    for (int i = 0; i < 14; i++) begin
      run_sample(tbl[i].vin, tbl[i].vg, got, lat, pulses, bz);
      check($sformatf("vec%0d_out", i), got, tbl[i].exp_out);
      check($sformatf("vec%0d_latency", i), lat, 6);
      check($sformatf("vec%0d_pulses", i), pulses, 1);
      check($sformatf("vec%0d_busy", i), int'(bz), 'h03F);
`ifdef MIXER_CLIP_COUNT_EN
      if (tbl[i].exp_clip) exp_clips++;
      check($sformatf("vec%0d_clip_count", i), int'(clip_count), exp_clips);
`endif
    end
    check("overrun_clear", int'(overrun), 0);

    // Second strobe two cycles after the first: only the second set is mixed.
    va = pack4(1000, 1000, 1000, 1000); ga = g4(128, 128, 128, 128);
    vb = pack4(-300, 200, 0, 7);        gb = g4(128, 128, 128, 128);
    model(vb, gb, exp_v, clip);
    @(negedge clk);
    in_v = va; gain_v = ga; audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    in_v = vb; audio_clk_en = 1'b1;
    got = 0; lat = -1; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      audio_clk_en = 1'b0;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin lat = k; got = int'($signed(out_w)); end
      end
    end
    check("overrun_flag", int'(overrun), 1);
    check("overrun_pulses", pulses, 1);
    check("overrun_value", got, exp_v);
    check("overrun_latency", lat, 6);

    // Inputs change the cycle after the strobe: result follows the snapshot.
    model(va, ga, exp_v, clip);
    @(negedge clk);
    in_v = va; gain_v = ga; audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0; in_v = vb; gain_v = g4(255, 3, 77, 255);
    got = 0; pulses = 0;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      if (out_valid) begin pulses++; got = int'($signed(out_w)); end
    end
    check("snapshot_value", got, exp_v);
    check("snapshot_pulses", pulses, 1);

    // Reset in the middle of accumulation.
    @(negedge clk);
    in_v = va; gain_v = ga; audio_clk_en = 1'b1;
    @(negedge clk);
    audio_clk_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out", int'(out_w), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_overrun", int'(overrun), 0);
`ifdef MIXER_CLIP_COUNT_EN
    exp_clips = 0;
    check("midrst_clip_count", int'(clip_count), 0);
`endif
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    check("midrst_no_valid", pulses, 0);
    run_sample(va, ga, got, lat, pulses, bz);
    check("post_rst_value", got, exp_v);
    check("post_rst_latency", lat, 6);

    for (int i = 0; i < 40; i++) begin
      va = {$urandom(), $urandom()};
      if (i % 2 == 1) ga = $urandom();
      else ga = g4($urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 40));
      model(va, ga, exp_v, clip);
      run_sample(va, ga, got, lat, pulses, bz);
      check($sformatf("rand%0d_out", i), got, exp_v);
      check($sformatf("rand%0d_pulses", i), pulses, 1);
`ifdef MIXER_CLIP_COUNT_EN
      if (clip) exp_clips++;
      check($sformatf("rand%0d_clip_count", i), int'(clip_count), exp_clips);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
